button_event: RTL and testbench

- Sits directly downstream of the button debouncer/synchronizer.
- Consumes the clean, synchronous button level and classifies it into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- UI/control logic on the Mojo board consumes these pulses instead of decoding raw levels.
- Timing is expressed in clock cycles; defaults assume the 50 MHz board clock.

---
 rtl/button_event.sv | 150 +++++++++++++++
 tb/tb_button_event.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Classifies a clean, synchronous button level into single-cycle event pulses:
// press, release, click, double-click, long-press and auto-repeat.
module button_event #(
  parameter int unsigned CTR_W      = 26,
  parameter int unsigned LONG_CYC   = 25000000,
  parameter int unsigned DBL_CYC    = 12500000,
  parameter int unsigned REPEAT_CYC = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dbl_o,
  output logic long_o,
  output logic repeat_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StWait2  = 3'd2,
    StPress2 = 3'd3,
    StLong   = 3'd4
  } state_e;

  localparam logic [CTR_W-1:0] LongTc   = CTR_W'(LONG_CYC - 1);
  localparam logic [CTR_W-1:0] DblTc    = CTR_W'(DBL_CYC - 1);
  localparam logic [CTR_W-1:0] RepeatTc = CTR_W'(REPEAT_CYC - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [CTR_W-1:0] r_ctr;
  logic [CTR_W-1:0] w_ctr_d;
  logic             r_btn;

  logic r_press, r_release, r_click, r_dbl, r_long, r_repeat;
  logic w_press, w_release, w_click, w_dbl, w_long, w_repeat;

  logic w_rise;
  logic w_fall;

  assign w_rise = btn_i & ~r_btn;
  assign w_fall = ~btn_i & r_btn;

  always_comb begin
    w_state_d = r_state;
    w_ctr_d   = (r_state == StIdle) ? '0 : r_ctr + 1'b1;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_click   = 1'b0;
    w_dbl     = 1'b0;
    w_long    = 1'b0;
    w_repeat  = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d = StPress1;
          w_press   = 1'b1;
        end
      end

      StPress1: begin
        if (w_fall) begin
          w_state_d = StWait2;
          w_release = 1'b1;
        end else if (r_ctr == LongTc) begin
          w_state_d = StLong;
          w_long    = 1'b1;
        end
      end

      StWait2: begin
        if (w_rise) begin
          w_state_d = StPress2;
          w_press   = 1'b1;
        end else if (r_ctr == DblTc) begin
          w_state_d = StIdle;
          w_click   = 1'b1;
        end
      end

      StPress2: begin
        if (w_fall) begin
          w_state_d = StIdle;
          w_release = 1'b1;
          w_dbl     = 1'b1;
        end else if (r_ctr == LongTc) begin
          // A second press held long becomes a long press; the double-click is dropped.
          w_state_d = StLong;
          w_long    = 1'b1;
        end
      end

      StLong: begin
        if (w_fall) begin
          w_state_d = StIdle;
          w_release = 1'b1;
        end else if (r_ctr == RepeatTc) begin
          w_repeat = 1'b1;
          w_ctr_d  = '0;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_state_d != r_state) begin
      w_ctr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_ctr     <= '0;
      r_btn     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_dbl     <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ctr     <= w_ctr_d;
      r_btn     <= btn_i;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_dbl     <= w_dbl;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
    end
  end

  assign held_o    = r_btn;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign click_o   = r_click;
  assign dbl_o     = r_dbl;
  assign long_o    = r_long;
  assign repeat_o  = r_repeat;

endmodule

// File: tb/tb_button_event.sv
// Table-driven bench for button_event with small timing parameters; each vector
// holds the button level and the output word expected after the following edge.
module tb_button_event;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_i;
  logic held_o, press_o, release_o, click_o, dbl_o, long_o, repeat_o;

  button_event #(
    .CTR_W     (4),
    .LONG_CYC  (8),
    .DBL_CYC   (6),
    .REPEAT_CYC(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn_i),
    .held_o   (held_o),
    .press_o  (press_o),
    .release_o(release_o),
    .click_o  (click_o),
    .dbl_o    (dbl_o),
    .long_o   (long_o),
    .repeat_o (repeat_o)
  );

  always #5 clk = ~clk;

  // Output word: {held, press, release, click, dbl, long, repeat}
  localparam logic [6:0] MP = 7'b0100000;
  localparam logic [6:0] MR = 7'b0010000;
  localparam logic [6:0] MC = 7'b0001000;
  localparam logic [6:0] MD = 7'b0000100;
  localparam logic [6:0] ML = 7'b0000010;
  localparam logic [6:0] MT = 7'b0000001;

  typedef struct packed {
    logic       btn;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [6:0] outs();
    return {held_o, press_o, release_o, click_o, dbl_o, long_o, repeat_o};
  endfunction

  function automatic void add_run(logic b, int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.btn = b;
      v.exp = {b, 6'b000000};
      vecs.push_back(v);
    end
  endfunction

  function automatic void mark(int idx, logic [6:0] m);
    vec_t v;
    v = vecs[idx];
    v.exp = v.exp | m;
    vecs[idx] = v;
  endfunction

  task automatic check(string name, int idx, logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b want %b (held,press,rel,click,dbl,long,rep)",
               name, idx, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic run_vecs(string name);
    for (int i = 0; i < vecs.size(); i++) begin
      btn_i = vecs[i].btn;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check(name, i, sb_q.pop_front());
    end
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, 7'b0);
    rst_n = 1'b1;

    add_run(1'b0, 50);
    run_vecs("idle");

    // Single click: release 3 after press, click 6 after release.
    add_run(1'b1, 3);
    add_run(1'b0, 12);
    mark(0, MP); mark(3, MR); mark(9, MC);
    run_vecs("click");

    // Double click: no click in the tail.
    add_run(1'b1, 3);
    add_run(1'b0, 2);
    add_run(1'b1, 3);
    add_run(1'b0, 21);
    mark(0, MP); mark(3, MR); mark(5, MP); mark(8, MR | MD);
    run_vecs("double");

    // Long press: release coincides with the third repeat terminal count, so no repeat then.
    add_run(1'b1, 20);
    add_run(1'b0, 10);
    mark(0, MP); mark(8, ML); mark(12, MT); mark(16, MT); mark(20, MR);
    run_vecs("long");

    // Release at PRESS1 terminal count: release wins over long.
    add_run(1'b1, 8);
    add_run(1'b0, 14);
    mark(0, MP); mark(8, MR); mark(14, MC);
    run_vecs("press1_tc");

    // Second rise at WAIT2 terminal count: press wins over click.
    add_run(1'b1, 3);
    add_run(1'b0, 6);
    add_run(1'b1, 3);
    add_run(1'b0, 12);
    mark(0, MP); mark(3, MR); mark(9, MP); mark(12, MR | MD);
    run_vecs("wait2_tc");

    // Async reset mid-WAIT2 (count 3): outputs clear at once, pending click dropped.
    add_run(1'b1, 3);
    add_run(1'b0, 4);
    mark(0, MP); mark(3, MR);
    run_vecs("pre_areset");
    rst_n = 1'b0;
    #1;
    check("areset", 0, 7'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_run(1'b0, 20);
    run_vecs("post_areset");

    // Button already pressed when reset deasserts: first cycle is a rise.
    rst_n = 1'b0;
    btn_i = 1'b1;
    #1;
    check("reset_btn_hi", 0, 7'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_run(1'b1, 3);
    add_run(1'b0, 12);
    mark(0, MP); mark(3, MR); mark(9, MC);
    run_vecs("rst_press");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
